// File: rtl/chunk_subtractor.sv
// chunk_subtractor: multi-cycle unsigned subtractor, CHUNK bits per cycle,
// LSB slice first, with the borrow carried between slices in a register.
// Optional zero-result flag port enabled by macro CHUNK_SUBTRACTOR_ZERO_FLAG_EN.
module chunk_subtractor #(
  parameter int BUS_SIZE = 32,
  parameter int CHUNK    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BUS_SIZE-1:0] a,
  input  logic [BUS_SIZE-1:0] b,
  input  logic                b_in,
  output logic [BUS_SIZE-1:0] out,
  output logic                underflow,
  output logic                busy,
  output logic                done
`ifdef CHUNK_SUBTRACTOR_ZERO_FLAG_EN
  ,
  output logic                zero
`endif
);

  localparam int N  = BUS_SIZE / CHUNK;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [BUS_SIZE-1:0] a_r;
  logic [BUS_SIZE-1:0] b_r;
  logic [BUS_SIZE-1:0] res;
  logic                borrow;
  logic [CW-1:0]       cnt;

  logic [CHUNK:0]      sub;
  logic [BUS_SIZE-1:0] slice_ext;
  logic [BUS_SIZE-1:0] next_res;
  logic                last;

  // Current slice difference; operands are shifted right so the active
  // slice is always the low CHUNK bits, and results enter res from the top.
  always_comb begin
    sub       = {1'b0, a_r[CHUNK-1:0]} - {1'b0, b_r[CHUNK-1:0]}
              - {{CHUNK{1'b0}}, borrow};
    slice_ext = '0;
    slice_ext[CHUNK-1:0] = sub[CHUNK-1:0];
    next_res  = (res >> CHUNK) | (slice_ext << (BUS_SIZE - CHUNK));
    last      = (cnt == CW'(N - 1));
  end

  // Control FSM and datapath registers; outputs are all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      res       <= '0;
      borrow    <= 1'b0;
      cnt       <= '0;
      out       <= '0;
      underflow <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef CHUNK_SUBTRACTOR_ZERO_FLAG_EN
      zero      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            borrow <= b_in;
            res    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_r    <= a_r >> CHUNK;
          b_r    <= b_r >> CHUNK;
          borrow <= sub[CHUNK];
          res    <= next_res;
          cnt    <= cnt + CW'(1);
          if (last) begin
            out       <= next_res;
            underflow <= sub[CHUNK];
`ifdef CHUNK_SUBTRACTOR_ZERO_FLAG_EN
            zero      <= (next_res == '0);
`endif
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_subtractor.sv
// Scoreboard bench for chunk_subtractor (BUS_SIZE=32, CHUNK=8).
module tb_chunk_subtractor;

  localparam int BUS_SIZE = 32;
  localparam int CHUNK    = 8;
  localparam int N        = BUS_SIZE / CHUNK;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [BUS_SIZE-1:0] a;
  logic [BUS_SIZE-1:0] b;
  logic                b_in;
  logic [BUS_SIZE-1:0] out;
  logic                underflow;
  logic                busy;
  logic                done;
`ifdef CHUNK_SUBTRACTOR_ZERO_FLAG_EN
  logic                zero;
`endif

  chunk_subtractor #(.BUS_SIZE(BUS_SIZE), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .b_in(b_in),
    .out(out), .underflow(underflow), .busy(busy), .done(done)
`ifdef CHUNK_SUBTRACTOR_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BUS_SIZE-1:0] res;
    logic                uf;
    int                  cyc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  // Reference: full-width unsigned arithmetic; expected done in the cycle
  // following the Nth edge after the accepting edge.
  function automatic void push(logic [BUS_SIZE-1:0] av, logic [BUS_SIZE-1:0] bv, logic bi);
    exp_t e;
    e.res = av - bv - BUS_SIZE'(bi);
    e.uf  = ({1'b0, av} < ({1'b0, bv} + (BUS_SIZE+1)'(bi)));
    e.cyc = cyc + N;
    q.push_back(e);
  endfunction

  // Monitor: pops on done, flags missing or unexpected results.
  always @(negedge clk) begin
    if (done) begin
      chk("busy_in_done", {63'b0, busy}, 64'd0);
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done got=1 exp=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out", {32'b0, out}, {32'b0, e.res});
        chk("underflow", {63'b0, underflow}, {63'b0, e.uf});
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
`ifdef CHUNK_SUBTRACTOR_ZERO_FLAG_EN
        chk("zero", {63'b0, zero}, {63'b0, (e.res == '0)});
`endif
      end
    end else if (q.size() > 0 && cyc >= q[0].cyc) begin
      checks++; errors++;
      $display("FAIL missing_done got=0 exp=1 (cycle %0d)", cyc);
      void'(q.pop_front());
    end
  end

  // Single operation: accept, scramble inputs, wait until the done cycle.
  task automatic issue(input logic [BUS_SIZE-1:0] av, input logic [BUS_SIZE-1:0] bv, input logic bi);
    a = av; b = bv; b_in = bi; start = 1'b1;
    @(posedge clk); #1;
    push(av, bv, bi);
    chk("busy_after_accept", {63'b0, busy}, 64'd1);
    start = 1'b0; a = $urandom; b = $urandom; b_in = 1'($urandom);
    repeat (N) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [BUS_SIZE-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {32'b0, out}, 64'd0);
    chk("rst_uf", {63'b0, underflow}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    rst = 1'b0;

    // Directed cases, first one started on the first edge after reset.
    issue(32'h0000_0005, 32'h0000_0003, 1'b0);
    issue(32'h0000_0000, 32'h0000_0001, 1'b0);
    issue(32'h0001_0000, 32'h0000_0001, 1'b0);
    issue(32'h1234_5678, 32'h1234_5678, 1'b1);
    issue(32'h1234_5678, 32'h1234_5678, 1'b0);
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    issue(32'h0000_0000, 32'hFFFF_FFFF, 1'b1);

    // Start re-pulsed at T+2 with other operands must be ignored.
    a = 32'h0000_1000; b = 32'h0000_0001; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    push(32'h0000_1000, 32'h0000_0001, 1'b0);
    start = 1'b0;
    @(posedge clk); #1;
    a = 32'hAAAA_AAAA; b = 32'h5555_5555; b_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (N - 2) @(posedge clk);
    #1;
    @(posedge clk); #1;

    // Reset at T+2 aborts: outputs cleared, no done afterwards.
    a = 32'h0000_0009; b = 32'h0000_0002; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_out", {32'b0, out}, 64'd0);
    chk("abort_uf", {63'b0, underflow}, 64'd0);
    repeat (N + 2) @(posedge clk);
    #1;

    // Random single operations.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : BUS_SIZE'($urandom);
      issue(ra, rb, 1'($urandom));
    end

    // Back-to-back: start held high, operands change every cycle.
    start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ra = $urandom; rb = $urandom;
      a = ra; b = rb; b_in = 1'($urandom);
      @(posedge clk); #1;
      push(ra, rb, b_in);
      for (int j = 0; j < N; j++) begin
        a = $urandom; b = $urandom; b_in = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    start = 1'b0;

    for (int w = 0; w < 20 && q.size() > 0; w++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain got=%0d exp=0 pending results", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
